execute_writeback_unit: RTL and testbench
=========================================

Name: execute_writeback_unit

Overview:
- Downstream stage of the 8x8 register file: consumes its two read-data outputs as operands, performs one ALU operation, and drives the file's write port (enable, register index, data) to write the result back.
- Simple ops are two-cycle; MUL is an iterative shift-add over WIDTH cycles.
- Single-issue with a start/busy/done handshake, driven by the control FSM.

Parameters:
- WIDTH, 8, operand/result width; equals register-file data width
- ADDR_WIDTH, 3, register index width (8 registers)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- destReg  input  ADDR_WIDTH  destination register index
- operand1  input  WIDTH  from register-file readData1
- operand2  input  WIDTH  from register-file readData2
- busy  output  1  high in EXEC and WB
- done  output  1  one-cycle pulse in WB
- writeEnable  output  1  to register-file enable; one-cycle pulse in WB
- writeRegister  output  ADDR_WIDTH  to register-file writeRegister
- writeData  output  WIDTH  to register-file writeData

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; busy, done, writeEnable = 0; writeRegister, writeData = 0. Internal latches and counter are cleared.
- States: IDLE, EXEC, WB.
- IDLE -> EXEC at an edge with start=1. Same edge latches opcode, destReg, operand1 and operand2. Later changes to the inputs do not affect the operation.
- Non-MUL op in EXEC: result is registered at the next edge, then go to WB.
- MUL: 8-bit step counter starts at 0. Each EXEC cycle: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift the multiplicand left and the multiplier right.
- MUL leaves EXEC after WIDTH steps (counter = WIDTH-1), then goes to WB.
- WB: writeEnable=1, done=1, busy=1 for exactly one cycle, then return to IDLE. writeRegister and writeData hold their values after WB until the next WB.
- Latency, start sampled at edge k: simple ops have writeEnable high in the cycle after edge k+1, so the register file writes at edge k+2. MUL has writeEnable high after edge k+WIDTH, so the write lands at edge k+WIDTH+1.
- Arithmetic: all results are modulo 2^WIDTH.
  - SUB = operand1 - operand2 with wrap.
  - SHL/SHR are logical shifts by operand2[2:0] with zero fill.
  - MUL returns the low WIDTH bits of the product.
- start while busy (EXEC or WB) is ignored; it is not queued.
- start in the IDLE cycle right after WB is accepted, giving back-to-back ops with no gap cycle.
- reset at any state, including mid-MUL: next state IDLE, and no writeEnable pulse is produced for the aborted op.
- destReg=0 is a normal write target; no register is protected.
- An undefined condition never occurs: all 8 opcodes are defined.

Optional Feature:
- Macro: EXEC_FLAGS_EN.
- Defined: adds outputs zeroFlag (1) and carryFlag (1). Both are registered, reset to 0, and update only at the edge entering WB; otherwise they hold.
  - zeroFlag = (result == 0).
  - carryFlag by opcode:
    - ADD: bit WIDTH of the sum.
    - SUB: borrow (operand1 < operand2).
    - SHL/SHR: the last bit shifted out; 0 if the shift amount is 0.
    - AND/OR/XOR: 0.
    - MUL: 1 if any product bit above WIDTH-1 is set.
- Undefined: flag ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD: reset held 2 cycles. Then start with opcode 0, op1=3, op2=5, destReg=2 -> outputs 0 during reset; writeEnable pulses once, 2 cycles after start; writeRegister=2, writeData=8; done coincides.
- SUB wrap plus flags: op1=3, op2=5 -> writeData=0xFE; with EXEC_FLAGS_EN, carryFlag=1 and zeroFlag=0. ADD 0xFF+0x01 -> writeData=0x00, zeroFlag=1, carryFlag=1.
- MUL: op1=13, op2=11, destReg=7 -> busy for 9 cycles; writeEnable asserted 9 cycles after start; writeData=0x8F (143). With the macro, 20*20=400 -> writeData=0x90, carryFlag=1.
- Shifts: SHL 0x81 by 1 -> writeData=0x02, carryFlag=1. SHR 0x81 by 3 -> writeData=0x10, carryFlag=0.
- Handshake: start held high across a MUL with op1 changing mid-op -> exactly one write, using the latched operands. A start in the cycle after WB immediately begins the next op.
- Reset mid-MUL: assert reset at step 4 -> no writeEnable pulse. Next cycle busy=0, writeData=0, and a new ADD then completes normally.

Source files
------------

// File: rtl/execute_writeback_unit.sv
// Execute/writeback stage: one ALU op on latched register-file operands, result written back.
// Optional EXEC_FLAGS_EN adds registered zeroFlag/carryFlag outputs.
module execute_writeback_unit #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] destReg,
    input  logic [WIDTH-1:0]      operand1,
    input  logic [WIDTH-1:0]      operand2,
    output logic                  busy,
    output logic                  done,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [WIDTH-1:0]      writeData
`ifdef EXEC_FLAGS_EN
    ,
    output logic                  zeroFlag,
    output logic                  carryFlag
`endif
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpShr = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    // Flag build keeps the full product (for MUL carry) and one extra carry bit.
`ifdef EXEC_FLAGS_EN
    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned ExtW = WIDTH + 1;
`else
    localparam int unsigned AccW = WIDTH;
    localparam int unsigned ExtW = WIDTH;
`endif

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e                state_q;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] dest_q;
    logic [AccW-1:0]       mcand_q;
    logic [AccW-1:0]       acc_q;
    logic [WIDTH-1:0]      mplier_q;
    logic [7:0]            count_q;

    logic [AccW-1:0]       mul_next;
    logic [2:0]            shamt;
    logic [WIDTH:0]        shr_tmp;
    logic [ExtW-1:0]       ext_res;
    logic                  exec_last;

    always_comb begin
        shamt     = mplier_q[2:0];
        mul_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        shr_tmp   = {mcand_q[WIDTH-1:0], 1'b0} >> shamt;
        exec_last = (op_q != OpMul) || (count_q == 8'(WIDTH - 1));
        ext_res   = '0;
        // Bit WIDTH of ext_res (flag build only) carries the op's carry/borrow/shifted-out bit.
        unique case (op_q)
            OpAdd: ext_res = ExtW'({1'b0, mcand_q[WIDTH-1:0]} + {1'b0, mplier_q});
            OpSub: ext_res = ExtW'({1'b0, mcand_q[WIDTH-1:0]} - {1'b0, mplier_q});
            OpAnd: ext_res = ExtW'(mcand_q[WIDTH-1:0] & mplier_q);
            OpOr:  ext_res = ExtW'(mcand_q[WIDTH-1:0] | mplier_q);
            OpXor: ext_res = ExtW'(mcand_q[WIDTH-1:0] ^ mplier_q);
            OpShl: ext_res = ExtW'({1'b0, mcand_q[WIDTH-1:0]} << shamt);
            OpShr: ext_res = ExtW'({shr_tmp[0], shr_tmp[WIDTH:1]});
            OpMul: ext_res = ExtW'(mul_next);
            default: ext_res = '0;
        endcase
    end

`ifdef EXEC_FLAGS_EN
    logic carry_next;
    always_comb begin
        carry_next = ext_res[WIDTH];
        if (op_q == OpMul) begin
            carry_next = |mul_next[AccW-1:WIDTH];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            op_q          <= '0;
            dest_q        <= '0;
            mcand_q       <= '0;
            acc_q         <= '0;
            mplier_q      <= '0;
            count_q       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            writeEnable   <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
`ifdef EXEC_FLAGS_EN
            zeroFlag      <= 1'b0;
            carryFlag     <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            writeEnable <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q     <= opcode;
                        dest_q   <= destReg;
                        mcand_q  <= AccW'(operand1);
                        mplier_q <= operand2;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy     <= 1'b1;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    if (exec_last) begin
                        writeData     <= ext_res[WIDTH-1:0];
                        writeRegister <= dest_q;
                        writeEnable   <= 1'b1;
                        done          <= 1'b1;
`ifdef EXEC_FLAGS_EN
                        zeroFlag      <= (ext_res[WIDTH-1:0] == '0);
                        carryFlag     <= carry_next;
`endif
                        state_q       <= StWb;
                    end else begin
                        acc_q    <= mul_next;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 8'd1;
                    end
                end
                StWb: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_writeback_unit.sv
// Randomized self-checking bench for execute_writeback_unit against an arithmetic reference model.
module tb_execute_writeback_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] opcode = '0;
    logic [2:0] destReg = '0;
    logic [7:0] operand1 = '0;
    logic [7:0] operand2 = '0;
    logic       busy, done, writeEnable;
    logic [2:0] writeRegister;
    logic [7:0] writeData;
`ifdef EXEC_FLAGS_EN
    logic       zeroFlag, carryFlag;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] last_data = '0;
    logic [2:0] last_reg  = '0;
    logic       last_z    = 1'b0;
    logic       last_c    = 1'b0;

    execute_writeback_unit #(.WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .destReg       (destReg),
        .operand1      (operand1),
        .operand2      (operand2),
        .busy          (busy),
        .done          (done),
        .writeEnable   (writeEnable),
        .writeRegister (writeRegister),
        .writeData     (writeData)
`ifdef EXEC_FLAGS_EN
        ,
        .zeroFlag      (zeroFlag),
        .carryFlag     (carryFlag)
`endif
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic on the opcode's meaning.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int c);
        int sh;
        int p;
        sh = b % 8;
        c  = 0;
        res = 0;
        case (op)
            0: begin p = a + b; res = p % 256; c = (p > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * (1 << sh)) % 256; c = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1); end
            6: begin res = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
            default: begin p = a * b; res = p % 256; c = (p > 255) ? 1 : 0; end
        endcase
    endfunction

    // Issue one op from an idle negedge; returns at the negedge one cycle after its WB.
    // hold=1 keeps start high through EXEC and WB while the inputs keep changing.
    task automatic run_op(input int op, input int a, input int b, input int dest, input bit hold);
        int res, c, lat;
        logic exp_busy, exp_we;
        model(op, a, b, res, c);
        lat = (op == 7) ? 8 : 1;
        opcode   = 3'(op);
        operand1 = 8'(a);
        operand2 = 8'(b);
        destReg  = 3'(dest);
        start    = 1'b1;
        @(posedge clock);
        for (int i = 0; i <= lat + 1; i++) begin
            @(negedge clock);
            if (!hold || i == lat + 1) start = 1'b0;
            operand1 = 8'($urandom);
            operand2 = 8'($urandom);
            opcode   = 3'($urandom);
            destReg  = 3'($urandom);
            exp_busy = (i <= lat);
            exp_we   = (i == lat);
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy op=%0d cyc=%0d got=%b exp=%b", op, i, busy, exp_busy);
            end
            checks++;
            if (writeEnable !== exp_we) begin
                errors++;
                $display("FAIL writeEnable op=%0d cyc=%0d got=%b exp=%b", op, i, writeEnable, exp_we);
            end
            checks++;
            if (done !== exp_we) begin
                errors++;
                $display("FAIL done op=%0d cyc=%0d got=%b exp=%b", op, i, done, exp_we);
            end
            checks++;
            if (i >= lat) begin
                if (writeData !== 8'(res)) begin
                    errors++;
                    $display("FAIL writeData op=%0d a=%0d b=%0d cyc=%0d got=%h exp=%h",
                             op, a, b, i, writeData, 8'(res));
                end
                checks++;
                if (writeRegister !== 3'(dest)) begin
                    errors++;
                    $display("FAIL writeRegister op=%0d cyc=%0d got=%0d exp=%0d",
                             op, i, writeRegister, dest);
                end
                checks++;
`ifdef EXEC_FLAGS_EN
                if (zeroFlag !== (res == 0) || carryFlag !== 1'(c)) begin
                    errors++;
                    $display("FAIL flags op=%0d a=%0d b=%0d got z=%b c=%b exp z=%b c=%b",
                             op, a, b, zeroFlag, carryFlag, (res == 0), 1'(c));
                end
                checks++;
`endif
            end else if (i == 0) begin
                if (writeData !== last_data || writeRegister !== last_reg) begin
                    errors++;
                    $display("FAIL hold_outputs op=%0d got reg=%0d data=%h exp reg=%0d data=%h",
                             op, writeRegister, writeData, last_reg, last_data);
                end
                checks++;
`ifdef EXEC_FLAGS_EN
                if (zeroFlag !== last_z || carryFlag !== last_c) begin
                    errors++;
                    $display("FAIL hold_flags op=%0d got z=%b c=%b exp z=%b c=%b",
                             op, zeroFlag, carryFlag, last_z, last_c);
                end
                checks++;
`endif
            end
        end
        last_data = 8'(res);
        last_reg  = 3'(dest);
        last_z    = (res == 0);
        last_c    = 1'(c);
    endtask

    task automatic check_idle_zero(input string tag);
        if ({busy, done, writeEnable} !== 3'b000) begin
            errors++;
            $display("FAIL %s_ctrl got busy=%b done=%b we=%b exp 0", tag, busy, done, writeEnable);
        end
        checks++;
        if (writeData !== 8'h00 || writeRegister !== 3'd0) begin
            errors++;
            $display("FAIL %s_data got reg=%0d data=%h exp 0", tag, writeRegister, writeData);
        end
        checks++;
`ifdef EXEC_FLAGS_EN
        if (zeroFlag !== 1'b0 || carryFlag !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags got z=%b c=%b exp 0", tag, zeroFlag, carryFlag);
        end
        checks++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_idle_zero("reset");
        end
        reset = 1'b0;
        last_data = '0;
        last_reg  = '0;
        last_z    = 1'b0;
        last_c    = 1'b0;
    endtask

    task automatic test_add();
        run_op(0, 3, 5, 2, 1'b0);
    endtask

    task automatic test_sub_flags();
        run_op(1, 3, 5, 4, 1'b0);
        run_op(0, 255, 1, 1, 1'b0);
    endtask

    task automatic test_mul();
        run_op(7, 13, 11, 7, 1'b0);
        run_op(7, 20, 20, 3, 1'b0);
    endtask

    task automatic test_shifts();
        run_op(5, 8'h81, 1, 5, 1'b0);
        run_op(6, 8'h81, 3, 6, 1'b0);
        run_op(5, 8'h81, 0, 0, 1'b0);
    endtask

    task automatic test_handshake();
        run_op(7, int'($urandom_range(255)), int'($urandom_range(255)), 1, 1'b1);
        run_op(0, 100, 27, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(4, 8'hA5, 8'h3C, 2, 1'b0);
        run_op(2, 8'hF0, 8'h3C, 3, 1'b0);
        run_op(7, 255, 255, 4, 1'b0);
        run_op(3, 8'h0F, 8'h30, 5, 1'b0);
    endtask

    task automatic test_mul_reset();
        opcode   = 3'd7;
        operand1 = 8'd200;
        operand2 = 8'd77;
        destReg  = 3'd5;
        start    = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (writeEnable !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL mulreset_pre cyc=%0d got we=%b busy=%b exp we=0 busy=1",
                         i, writeEnable, busy);
            end
            checks++;
        end
        reset = 1'b1;
        @(negedge clock);
        check_idle_zero("mulreset");
        reset = 1'b0;
        last_data = '0;
        last_reg  = '0;
        last_z    = 1'b0;
        last_c    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (writeEnable !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mulreset_post cyc=%0d got we=%b busy=%b exp 0", i, writeEnable, busy);
            end
            checks++;
        end
        run_op(0, 40, 2, 6, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(7)), int'($urandom_range(255)),
                   int'($urandom_range(255)), int'($urandom_range(7)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_flags();
        test_mul();
        test_shifts();
        test_handshake();
        test_back_to_back();
        test_mul_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
